ra_64x72_ctl: RTL

RA_64X72_CTL -- requirements
Module: ra_64x72_ctl

---
 rtl/ra_64x72_ctl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ra_64x72_ctl.sv
// ra_64x72_ctl: control for a 64-entry x 72-bit register array with two
// write clients sharing one array write port and two independent read ports.
// Optional power-up initialisation sweep is enabled by defining RA_CTL_INIT_EN;
// without it the block comes out of reset directly in normal service.
module ra_64x72_ctl #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr0_req,
    input  logic [5:0]  wr0_adr,
    input  logic [71:0] wr0_dat,
    output logic        wr0_gnt,
    input  logic        wr1_req,
    input  logic [5:0]  wr1_adr,
    input  logic [71:0] wr1_dat,
    output logic        wr1_gnt,
    input  logic        rd0_req,
    input  logic [5:0]  rd0_adr,
    output logic        rd0_rdy,
    output logic        rd0_vld,
    input  logic        rd1_req,
    input  logic [5:0]  rd1_adr,
    output logic        rd1_rdy,
    output logic        rd1_vld,
    output logic        init_done,
    output logic        ra_rd_enb_0,
    output logic [5:0]  ra_rd_adr_0,
    output logic        ra_rd_enb_1,
    output logic [5:0]  ra_rd_adr_1,
    output logic        ra_wr_enb_0,
    output logic [5:0]  ra_wr_adr_0,
    output logic [71:0] ra_wr_dat_0
);

    localparam int ADR_W  = 6;
    localparam int DATA_W = 72;

    logic              in_init;
    logic [ADR_W-1:0]  init_adr;
    logic              last_gnt1;
    logic              pick0;
    logic              pick1;
    logic              wr_any;
    logic [RD_LAT-1:0] vld0_sr;
    logic [RD_LAT-1:0] vld1_sr;

`ifdef RA_CTL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ADR_W-1:0] init_cnt;
    logic [ADR_W-1:0] init_cnt_nxt;

    // State register and init sweep counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next state: sweep every entry once, then switch to normal service
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        in_init      = 1'b0;
        case (state)
            ST_INIT: begin
                in_init      = 1'b1;
                init_cnt_nxt = init_cnt + 6'd1;
                if (init_cnt == 6'd63) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                in_init = 1'b0;
            end
        endcase
    end

    assign init_adr  = init_cnt;
    assign init_done = (state == ST_RUN);
`else
    assign in_init   = 1'b0;
    assign init_adr  = '0;
    assign init_done = 1'b1;
`endif

    // Round-robin winner: on contention the side not granted last time wins
    always_comb begin
        pick1 = wr1_req & (~wr0_req | ~last_gnt1);
        pick0 = wr0_req & ~pick1;
    end

    // Array write port: init sweep, granted client, or idle zeros
    always_comb begin
        wr0_gnt     = 1'b0;
        wr1_gnt     = 1'b0;
        ra_wr_enb_0 = 1'b0;
        ra_wr_adr_0 = '0;
        ra_wr_dat_0 = '0;
        if (!reset) begin
            if (in_init) begin
                ra_wr_enb_0 = 1'b1;
                ra_wr_adr_0 = init_adr;
            end else if (pick0) begin
                wr0_gnt     = 1'b1;
                ra_wr_enb_0 = 1'b1;
                ra_wr_adr_0 = wr0_adr;
                ra_wr_dat_0 = wr0_dat;
            end else if (pick1) begin
                wr1_gnt     = 1'b1;
                ra_wr_enb_0 = 1'b1;
                ra_wr_adr_0 = wr1_adr;
                ra_wr_dat_0 = wr1_dat;
            end
        end
    end

    assign wr_any = wr0_gnt | wr1_gnt;

    // Read acceptance: stall a read that targets the entry being written now
    always_comb begin
        rd0_rdy     = 1'b0;
        rd1_rdy     = 1'b0;
        ra_rd_enb_0 = 1'b0;
        ra_rd_enb_1 = 1'b0;
        ra_rd_adr_0 = '0;
        ra_rd_adr_1 = '0;
        if (!reset && !in_init) begin
            rd0_rdy = rd0_req & ~(wr_any & (ra_wr_adr_0 == rd0_adr));
            rd1_rdy = rd1_req & ~(wr_any & (ra_wr_adr_0 == rd1_adr));
        end
        ra_rd_enb_0 = rd0_req & rd0_rdy;
        ra_rd_enb_1 = rd1_req & rd1_rdy;
        if (ra_rd_enb_0) begin
            ra_rd_adr_0 = rd0_adr;
        end
        if (ra_rd_enb_1) begin
            ra_rd_adr_1 = rd1_adr;
        end
    end

    // Round-robin pointer: remembers the last granted client; starts favouring wr0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt1 <= 1'b1;
        end else if (wr0_gnt) begin
            last_gnt1 <= 1'b0;
        end else if (wr1_gnt) begin
            last_gnt1 <= 1'b1;
        end
    end

    // Read-valid delay lines, one per read port, RD_LAT stages deep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld0_sr <= '0;
            vld1_sr <= '0;
        end else begin
            vld0_sr[0] <= ra_rd_enb_0;
            vld1_sr[0] <= ra_rd_enb_1;
            for (int i = 1; i < RD_LAT; i++) begin
                vld0_sr[i] <= vld0_sr[i-1];
                vld1_sr[i] <= vld1_sr[i-1];
            end
        end
    end

    assign rd0_vld = vld0_sr[RD_LAT-1];
    assign rd1_vld = vld1_sr[RD_LAT-1];

endmodule
